// File: rtl/lsu_pkg.sv
// Purpose: shared types and helpers for the load/store unit (size codes,
//          memory command encoding, FSM state, split-access helpers).
// Ports:   none (package).
package lsu_pkg;

  localparam int XLEN = 32;

  // Request size codes as seen on req_size.
  typedef logic [1:0] lsu_size_t;
  localparam lsu_size_t SIZE_WORD    = 2'd0;
  localparam lsu_size_t SIZE_HALF    = 2'd1;
  localparam lsu_size_t SIZE_BYTE    = 2'd2;
  localparam lsu_size_t SIZE_ILLEGAL = 2'd3;

  // Data-memory command encoding (memReadCommand / memWriteCommand).
  // Deliberately identical to the legal size codes so an aligned access
  // can forward req_size straight to the memory.
  typedef logic [1:0] mem_cmd_t;
  localparam mem_cmd_t CMD_WORD = 2'd0;
  localparam mem_cmd_t CMD_HALF = 2'd1;
  localparam mem_cmd_t CMD_BYTE = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2
  } lsu_state_e;

  // Index of the last access cycle (N-1): 0 for a native access,
  // 1 for a misaligned half (two bytes), 3 for a misaligned word (four bytes).
  function automatic logic [1:0] last_beat(input lsu_size_t size,
                                           input logic [1:0] addr_lo);
    logic [1:0] last;
    last = 2'd0;
    if (size == SIZE_WORD && addr_lo != 2'd0) last = 2'd3;
    if (size == SIZE_HALF && addr_lo[0])      last = 2'd1;
    return last;
  endfunction

  // Byte lane sel of a right-justified store value (lane 0 = bits 7:0).
  // A split store walks lanes from most to least significant so the MSB
  // lands at the lowest address (big-endian).
  function automatic logic [7:0] split_byte(input logic [31:0] wdata,
                                            input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = wdata[7:0];
      2'd1:    b = wdata[15:8];
      2'd2:    b = wdata[23:16];
      default: b = wdata[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Purpose: sign/zero extension of load data to 32 bits, combinational.
// Ports:   raw_i (raw data, low bytes significant), size_i (lsu size code),
//          unsigned_i (zero-extend), ext_o (extended result).
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] raw_i,
  input  lsu_size_t       size_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] ext_o
);

  // Upper bits of raw_i are ignored for half/byte: the memory's own sign
  // extension is discarded and rebuilt from the low bits.
  always_comb begin
    ext_o = raw_i;
    case (size_i)
      SIZE_HALF: ext_o = unsigned_i ? {16'h0000, raw_i[15:0]}
                                    : {{16{raw_i[15]}}, raw_i[15:0]};
      SIZE_BYTE: ext_o = unsigned_i ? {24'h000000, raw_i[7:0]}
                                    : {{24{raw_i[7]}}, raw_i[7:0]};
      default:   ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Purpose: MEM-stage load/store initiator for a big-endian data memory;
//          misaligned half/word accesses are split into byte accesses.
// Ports:   Clock/Reset; req_* valid/ready request; rsp_* one-cycle response;
//          mem_* data memory port (writes on posedge, reads on negedge).
module load_store_unit
  import lsu_pkg::*;
(
  input  logic            Clock,
  input  logic            Reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            mem_W_en,
  output logic            mem_R_en,
  output logic [XLEN-1:0] mem_Address,
  output logic [XLEN-1:0] mem_W_data,
  output logic [1:0]      mem_memReadCommand,
  output logic [1:0]      mem_memWriteCommand,
  input  logic [XLEN-1:0] mem_R_data
);

  lsu_state_e      state_q;
  logic            write_q;
  lsu_size_t       size_q;
  logic            unsigned_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [1:0]      last_q;   // N-1
  logic [1:0]      k_q;      // current byte index within a split access
  logic [XLEN-1:0] acc_q;

  logic            rsp_valid_q;
  logic [XLEN-1:0] rsp_rdata_q;
  logic            rsp_err_q;

  // Memory port is driven from registers loaded one edge ahead, so each
  // access cycle presents stable address/data for the whole cycle.
  logic            mem_w_en_q;
  logic            mem_r_en_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic [1:0]      mem_rcmd_q;
  logic [1:0]      mem_wcmd_q;

  logic [1:0]      accept_last;
  mem_cmd_t        accept_cmd;
  logic [XLEN-1:0] accept_wdata;
  logic [1:0]      k_d;
  logic [XLEN-1:0] acc_d;
  logic [XLEN-1:0] ext_raw;
  logic [XLEN-1:0] ext_data;

  // First access of a newly accepted request.
  assign accept_last  = last_beat(req_size, req_addr[1:0]);
  assign accept_cmd   = (accept_last == 2'd0) ? req_size : CMD_BYTE;
  assign accept_wdata = (accept_last == 2'd0) ? req_wdata
                                              : {24'h000000, split_byte(req_wdata, accept_last)};

  assign k_d   = k_q + 2'd1;
  // Split loads shift bytes in MSB-first, matching big-endian order.
  assign acc_d = {acc_q[23:0], mem_R_data[7:0]};
  // A native access extends the memory word directly; a split one extends
  // the accumulator including the byte arriving on this edge.
  assign ext_raw = (last_q == 2'd0) ? mem_R_data : acc_d;

  lsu_extend u_extend (
    .raw_i      (ext_raw),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .ext_o      (ext_data)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      size_q      <= SIZE_WORD;
      unsigned_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      last_q      <= 2'd0;
      k_q         <= 2'd0;
      acc_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_w_en_q  <= 1'b0;
      mem_r_en_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rcmd_q  <= CMD_WORD;
      mem_wcmd_q  <= CMD_WORD;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (req_size == SIZE_ILLEGAL) begin
              state_q <= ERR;
            end else begin
              state_q     <= ACCESS;
              write_q     <= req_write;
              size_q      <= req_size;
              unsigned_q  <= req_unsigned;
              addr_q      <= req_addr;
              wdata_q     <= req_wdata;
              last_q      <= accept_last;
              k_q         <= 2'd0;
              acc_q       <= '0;
              mem_addr_q  <= req_addr;
              mem_w_en_q  <= req_write;
              mem_r_en_q  <= !req_write;
              mem_wcmd_q  <= req_write ? accept_cmd : CMD_WORD;
              mem_rcmd_q  <= req_write ? CMD_WORD : accept_cmd;
              mem_wdata_q <= req_write ? accept_wdata : '0;
            end
          end
        end

        ACCESS: begin
          acc_q <= acc_d;
          if (k_q == last_q) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= write_q ? '0 : ext_data;
            mem_w_en_q  <= 1'b0;
            mem_r_en_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rcmd_q  <= CMD_WORD;
            mem_wcmd_q  <= CMD_WORD;
          end else begin
            // Next byte of a split access; address wraps modulo 2^32.
            k_q         <= k_d;
            mem_addr_q  <= addr_q + {30'd0, k_d};
            mem_wdata_q <= write_q ? {24'h000000, split_byte(wdata_q, last_q - k_d)} : '0;
          end
        end

        ERR: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
          rsp_rdata_q <= '0;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready           = (state_q == IDLE) && !Reset;
  assign rsp_valid           = rsp_valid_q;
  assign rsp_rdata           = rsp_rdata_q;
  assign rsp_err             = rsp_err_q;
  assign mem_W_en            = mem_w_en_q;
  assign mem_R_en            = mem_r_en_q;
  assign mem_Address         = mem_addr_q;
  assign mem_W_data          = mem_wdata_q;
  assign mem_memReadCommand  = mem_rcmd_q;
  assign mem_memWriteCommand = mem_wcmd_q;

endmodule
